// File: rtl/bit_scatter_reg_pkg.sv
// Shared definitions for bit_scatter_reg.
// Provides the default word/select widths and the FILL/HOLD state encoding.
package bit_scatter_reg_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned SEL_W_DEF = 5;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/decoder_5_to_32.sv
// Select-to-one-hot decoder: the structural inverse of MUX_32_to_1.
// Ports:
//   sel    - bit position to address
//   en     - enable; when low the output is all zeros
//   onehot - one-hot write-enable vector, bit sel set when en is high
module decoder_5_to_32 #(
  parameter int unsigned SEL_W = 5,
  parameter int unsigned WIDTH = 32
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/bit_scatter_reg.sv
// Bit-scatter register: deposits single bits into addressed positions of a
// word and presents the word on a valid/ready handshake once every position
// has been written at least once.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - write handshake (ready only while filling)
//   sel, d              - target bit position and bit value
//   flush               - discard partial or held word, return to filling
//   out_word            - assembled word, stable while out_valid is high
//   out_valid/out_ready - output handshake
//   written_mask        - positions written since the last clear
//   fill_count          - population count of written_mask
module bit_scatter_reg
  import bit_scatter_reg_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             d,
  input  logic             flush,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] written_mask,
  output logic [SEL_W:0]   fill_count
);

  localparam logic [SEL_W:0] COUNT_ONE  = (SEL_W+1)'(1);
  localparam logic [SEL_W:0] COUNT_LAST = (SEL_W+1)'(WIDTH - 1);

  state_t           state, state_next;
  logic             wr_accept;
  logic             wr_new;
  logic [WIDTH-1:0] wr_en;

  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);
  assign wr_accept = in_valid && in_ready;
  // A write only grows the mask when its position was still unwritten.
  assign wr_new    = wr_accept && !written_mask[sel];

  decoder_5_to_32 #(
    .SEL_W (SEL_W),
    .WIDTH (WIDTH)
  ) u_dec (
    .sel    (sel),
    .en     (wr_accept),
    .onehot (wr_en)
  );

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL: if (wr_new && fill_count == COUNT_LAST) state_next = HOLD;
        HOLD: if (out_ready) state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Word, mask and count are cleared by reset, flush, or a completed
  // handoff; otherwise only updated by accepted writes (in_ready gates
  // wr_en, so HOLD freezes them).
  always_ff @(posedge clk) begin
    if (rst || flush || (state == HOLD && out_ready)) begin
      out_word     <= '0;
      written_mask <= '0;
      fill_count   <= '0;
    end else begin
      out_word     <= (out_word & ~wr_en) | (d ? wr_en : '0);
      written_mask <= written_mask | wr_en;
      if (wr_new) fill_count <= fill_count + COUNT_ONE;
    end
  end

endmodule

// File: tb/tb_bit_scatter_reg.sv
module tb_bit_scatter_reg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SEL_W = 5;

  logic             clk = 1'b0;
  logic             rst, in_valid, d, flush, out_ready;
  logic [SEL_W-1:0] sel;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_word, written_mask;
  logic [SEL_W:0]   fill_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-position bit values and written flags.
  bit m_bit[WIDTH];
  bit m_wr[WIDTH];
  bit m_hold;

  bit_scatter_reg #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sel          (sel),
    .d            (d),
    .flush        (flush),
    .out_word     (out_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .written_mask (written_mask),
    .fill_count   (fill_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < WIDTH; i++) begin
      m_bit[i] = 1'b0;
      m_wr[i]  = 1'b0;
    end
    m_hold = 1'b0;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += m_wr[i];
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] model_word();
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH; i++) w[i] = m_bit[i];
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] model_mask();
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH; i++) w[i] = m_wr[i];
    return w;
  endfunction

  // One clock: drive inputs on the falling edge, advance the model by the
  // spec rules, then compare every output shortly after the rising edge.
  task automatic cycle(input bit r, input bit iv, input int s, input bit dv,
                       input bit fl, input bit ordy);
    @(negedge clk);
    rst = r; in_valid = iv; sel = SEL_W'(s); d = dv; flush = fl; out_ready = ordy;
    if (r || fl) begin
      model_clear();
    end else if (!m_hold) begin
      if (iv) begin
        m_bit[s] = dv;
        m_wr[s]  = 1'b1;
        if (model_count() == WIDTH) m_hold = 1'b1;
      end
    end else if (ordy) begin
      model_clear();
    end
    @(posedge clk);
    #1;
    check("out_word",  64'(out_word),     64'(model_word()));
    check("mask",      64'(written_mask), 64'(model_mask()));
    check("count",     64'(fill_count),   64'(model_count()));
    check("out_valid", 64'(out_valid),    64'(m_hold));
    check("in_ready",  64'(in_ready),     64'(!m_hold));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  int perm[WIDTH];
  int prev_cnt;
  int valid_rises;
  bit prev_valid;

  initial begin
    rst = 1'b1; in_valid = 0; sel = '0; d = 0; flush = 0; out_ready = 0;
    model_clear();

    // Reset, then reset mid-fill after 10 writes.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, i * 3, 1, 0, 0);
    cycle(1, 1, 5, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("rst_word", 64'(out_word), 64'h0);
    check("rst_ready", 64'(in_ready), 64'h1);

    // Ascending fill, alternating data.
    for (int i = 0; i < WIDTH; i++) cycle(0, 1, i, bit'(i % 2), 0, 0);
    check("asc_valid", 64'(out_valid), 64'h1);
    check("asc_word", 64'(out_word), 64'hAAAAAAAA);
    cycle(0, 0, 0, 0, 0, 1);
    check("asc_mask_clr", 64'(written_mask), 64'h0);

    // Rewrite of position 3.
    cycle(0, 1, 3, 1, 0, 0);
    cycle(0, 1, 3, 0, 0, 0);
    check("rw_count", 64'(fill_count), 64'h1);
    for (int i = 0; i < WIDTH; i++) if (i != 3) cycle(0, 1, i, 1, 0, 0);
    check("rw_word", 64'(out_word), 64'hFFFFFFF7);
    cycle(0, 0, 0, 0, 0, 1);

    // Backpressure: writes during HOLD must be ignored.
    for (int i = 0; i < WIDTH; i++) cycle(0, 1, WIDTH - 1 - i, bit'($urandom_range(1)), 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, $urandom_range(WIDTH - 1), 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 1);
    check("bp_ready", 64'(in_ready), 64'h1);
    idle(2);

    // Flush with a simultaneous write, then flush during HOLD with out_ready.
    for (int i = 0; i < 20; i++) cycle(0, 1, i, 1, 0, 0);
    cycle(0, 1, 7, 1, 1, 0);
    check("fl_count", 64'(fill_count), 64'h0);
    for (int i = 0; i < WIDTH; i++) cycle(0, 1, i, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 1);
    check("fl_hold_valid", 64'(out_valid), 64'h0);
    idle(1);

    // Random permutations with random data and random idle gaps.
    for (int rep = 0; rep < 4; rep++) begin
      for (int i = 0; i < WIDTH; i++) perm[i] = i;
      for (int i = WIDTH - 1; i > 0; i--) begin
        int j, t;
        j = $urandom_range(i);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      prev_cnt = 0; valid_rises = 0; prev_valid = 0;
      for (int i = 0; i < WIDTH; i++) begin
        if ($urandom_range(3) == 0) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, perm[i], bit'($urandom_range(1)), 0, 0);
        check("mono", 64'(int'(fill_count) >= prev_cnt), 64'h1);
        prev_cnt = int'(fill_count);
        if (out_valid && !prev_valid) valid_rises++;
        prev_valid = out_valid;
      end
      for (int k = 0; k < 3; k++) begin
        cycle(0, 1, $urandom_range(WIDTH - 1), 1, 0, 0);
        if (out_valid && !prev_valid) valid_rises++;
        prev_valid = out_valid;
      end
      check("rand_once", 64'(valid_rises), 64'h1);
      cycle(0, 0, 0, 0, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_scatter_reg.md
Name: bit_scatter_reg

Overview:
- Write-side counterpart of the 32-to-1 bit selector: it deposits single bits into addressed positions of a 32-bit word instead of extracting them.
- Each accepted write stores bit `d` at position `sel`.
- Once every position has been written at least once, the assembled word is presented on a valid/ready output handshake.
- Used by the Sort datapath to build words bit-by-bit, and as the write path feeding bit-addressed MUX readers.

Parameters:
- WIDTH, 32, assembled word width; must equal 2**SEL_W.
- SEL_W, 5, bit-position select width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  write request.
- in_ready  output  1  write accepted when in_valid && in_ready at a clk edge.
- sel  input  SEL_W  target bit position.
- d  input  1  bit value to store.
- flush  input  1  discard partial word; return to FILL.
- out_word  output  WIDTH  assembled word; stable while out_valid is high.
- out_valid  output  1  assembled word available.
- out_ready  input  1  consumer takes the word when out_valid && out_ready.
- written_mask  output  WIDTH  bit i is 1 if position i has been written since the last clear.
- fill_count  output  SEL_W+1  number of set bits in written_mask (0..WIDTH).

Behaviour:
- Reset: clk and rst as named above; reset is synchronous and active-high.
  - On rst, next edge: state=FILL, out_word=0, written_mask=0, fill_count=0, out_valid=0.
  - in_ready=1 after reset (combinational from state).
  - rst has priority over all other inputs.
- States:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- FILL, accepted write:
  - out_word[sel] <= d; written_mask[sel] <= 1.
  - fill_count increments only if written_mask[sel] was 0.
  - A rewrite of an already-written position overwrites the bit; mask and count are unchanged.
- FILL to HOLD: on the edge where the write completes the mask (fill_count reaches WIDTH).
  - out_valid is high in the very next cycle. Latency from last distinct write to out_valid is 1 cycle.
- HOLD:
  - Writes are ignored (in_ready=0).
  - out_word, mask and count are frozen.
  - On an edge with out_ready=1: state=FILL, out_word=0, written_mask=0, fill_count=0.
  - in_ready is high in the following cycle. There is no write bypass in the handoff cycle.
- flush (priority below rst, above everything else):
  - In either state: clear word, mask and count; state=FILL.
  - A write presented in the same cycle is dropped.
  - A word held in HOLD is discarded, even if out_ready=1 in that cycle.
- out_valid never drops without an accepted out_ready, except on flush or rst.
- No combinational path from in_valid/d/sel to out_valid or out_word.
- sel is always in range because WIDTH == 2**SEL_W.

Decomposition:
- Shared header: WIDTH/SEL_W defaults and FILL/HOLD state encodings (1 bit, FILL=0).
- One sub-module: decoder_5_to_32.
  - Ports: one-hot output, select input, enable input.
  - Generates per-bit write enables from sel gated by in_valid && in_ready.
  - This is the structural inverse of MUX_32_to_1.
- Parent holds the state register, word register, mask register and count.

Test Plan:
- Reset: assert rst for 2 cycles mid-fill after 10 writes -> out_word=0, written_mask=0, fill_count=0, out_valid=0, in_ready=1.
- Ascending fill: write sel=0..31 with d=sel[0] on consecutive cycles -> out_valid high 1 cycle after sel=31, out_word=32'hAAAAAAAA; with out_ready=1 it returns to FILL, mask=0.
- Rewrite: write sel=3,d=1 then sel=3,d=0 -> fill_count=1, out_word[3]=0; complete the remaining 31 with d=1 -> out_word=32'hFFFFFFF7.
- Backpressure: fill the word with out_ready=0 for 5 cycles while in_valid=1 with d=0 -> out_word held stable, in_ready=0, writes ignored; then out_ready=1 -> one transfer, in_ready=1 next cycle.
- Flush: 20 writes then flush with a simultaneous write at sel=7 -> fill_count=0, out_word=0, write dropped; flush during HOLD with out_ready=1 -> no transfer, state FILL.
- Random order: random permutation of 0..31 with random d -> out_word matches the scoreboard, out_valid exactly once, fill_count monotone.
